// File: rtl/mcu51_timing_pkg.sv
// Shared encodings for the MCU51-style machine-cycle timing core, plus the
// opcode-to-cycle-count helper used by the upstream decoder.
package mcu51_timing_pkg;

  typedef enum logic [2:0] {
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } s_state_e;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  // Extra machine cycles beyond the first; the decoder resizes this to CYC_W.
  function automatic logic [1:0] extra_cycles(input logic [7:0] opcode);
    logic [1:0] n;
    n = 2'd0;
    casez (opcode)
      8'h84, 8'hA4:                               n = 2'd3;
      8'b????_0001,
      8'h02, 8'h12, 8'h22, 8'h32,
      8'h10, 8'h20, 8'h30, 8'h40, 8'h50,
      8'h60, 8'h70, 8'h73, 8'h80,
      8'h83, 8'h93, 8'h90, 8'hA3,
      8'hC0, 8'hD0, 8'hD5,
      8'hE0, 8'hE2, 8'hE3, 8'hF0, 8'hF2, 8'hF3,
      8'h43, 8'h53, 8'h63, 8'h72, 8'h82,
      8'h75, 8'h85, 8'h86, 8'h87, 8'h92,
      8'hA0, 8'hA6, 8'hA7, 8'hB0,
      8'b1000_1???, 8'b1010_1???,
      8'b1011_01??, 8'b1011_1???, 8'b1101_1???:  n = 2'd1;
      default:                                    n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bus_wait_ctrl.sv
// Bus-window stretcher: programmable wait states followed, on MOVX data
// windows, by an xmem_ready hold bounded by a timeout.
module bus_wait_ctrl #(
  parameter int WAIT_W = 2,
  parameter int RDY_TO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_req,
  input  logic              enter_win,
  input  logic              enter_rdy,
  input  logic [WAIT_W-1:0] wait_cfg,
  input  logic              xmem_ready,
  output logic              hold,
  output logic              waiting,
  output logic              bus_err
);

  localparam int TO_W = $clog2(RDY_TO + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              rdy_en;
  logic              hold_q;

  // hold_q is the decision for the coming clock, so xmem_ready is sampled
  // on the edge where the wait count runs out (or the window is entered).
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      to_cnt   <= '0;
      rdy_en   <= 1'b0;
      hold_q   <= 1'b0;
      bus_err  <= 1'b0;
    end else if (stall_req) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (!hold_q) begin
        if (enter_win) begin
          wait_cnt <= wait_cfg;
          rdy_en   <= enter_rdy;
          to_cnt   <= '0;
          if (wait_cfg != '0) begin
            hold_q <= 1'b1;
          end else if (enter_rdy && !xmem_ready) begin
            hold_q <= 1'b1;
            to_cnt <= TO_W'(1);
          end
        end
      end else if (wait_cnt > WAIT_W'(1)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end else if (wait_cnt == WAIT_W'(1)) begin
        wait_cnt <= '0;
        if (rdy_en && !xmem_ready) begin
          to_cnt <= TO_W'(1);
        end else begin
          hold_q <= 1'b0;
        end
      end else if (xmem_ready) begin
        hold_q <= 1'b0;
      end else if (to_cnt == TO_W'(RDY_TO)) begin
        hold_q  <= 1'b0;
        bus_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign hold    = hold_q;
  assign waiting = hold_q;

endmodule

// File: rtl/mcycle_timing_gen.sv
// Machine-cycle timing generator: P1/P2 and S1..S6 sequencing, multi-cycle
// instruction counting and registered external-bus strobes.
module mcycle_timing_gen
  import mcu51_timing_pkg::*;
#(
  parameter int CYC_W  = 2,
  parameter int WAIT_W = 2,
  parameter int RDY_TO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_req,
  input  logic [CYC_W-1:0]  cyc_load_val,
  input  logic              movx_rd,
  input  logic              movx_wr,
  input  logic [WAIT_W-1:0] wait_cfg,
  input  logic              xmem_ready,
  output logic              phase,
  output logic [2:0]        s_state,
  output logic [CYC_W-1:0]  cycles_rem,
  output logic              ale,
  output logic              psen_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              ir_en,
  output logic              dec_ld,
  output logic              waiting,
  output logic              bus_err
);

  s_state_e         s_q, s_nxt;
  logic             phase_q, phase_nxt;
  logic [CYC_W-1:0] rem_q, rem_nxt;
  logic             mv_rd_q, mv_rd_nxt;
  logic             mv_wr_q, mv_wr_nxt;
  logic             need_ld_q, need_ld_nxt;
  logic             hold, adv, end_instr, do_load;
  logic             data_nxt, pre_nxt, enter_win, enter_rdy;

  function automatic logic ale_on(input logic ph, input s_state_e s, input logic data);
    return ((((s == S1) && (ph == P2)) || ((s == S2) && (ph == P1))) && !data) ||
           ((s == S4) && (ph == P2)) || ((s == S5) && (ph == P1));
  endfunction

  function automatic logic psen_on(input logic ph, input s_state_e s, input logic data,
                                   input logic pre);
    return ((((s == S2) && (ph == P2)) || (s == S3)) && !data) ||
           ((((s == S5) && (ph == P2)) || (s == S6)) && !pre);
  endfunction

  function automatic logic xstrobe_on(input logic ph, input s_state_e s, input logic data);
    return data && (((s == S1) && (ph == P2)) || (s == S2) || (s == S3));
  endfunction

  bus_wait_ctrl #(
    .WAIT_W (WAIT_W),
    .RDY_TO (RDY_TO)
  ) u_wait (
    .clk        (clk),
    .reset      (reset),
    .stall_req  (stall_req),
    .enter_win  (enter_win),
    .enter_rdy  (enter_rdy),
    .wait_cfg   (wait_cfg),
    .xmem_ready (xmem_ready),
    .hold       (hold),
    .waiting    (waiting),
    .bus_err    (bus_err)
  );

  always_comb begin
    adv         = !stall_req && !hold;
    phase_nxt   = phase_q;
    s_nxt       = s_q;
    rem_nxt     = rem_q;
    mv_rd_nxt   = mv_rd_q;
    mv_wr_nxt   = mv_wr_q;
    need_ld_nxt = need_ld_q;
    end_instr   = adv && (phase_q == P2) && (s_q == S6) && (rem_q == '0);
    do_load     = adv && (phase_q == P2) && (s_q == S1) && need_ld_q;
    if (adv) begin
      phase_nxt = ~phase_q;
      if (phase_q == P2) begin
        s_nxt = (s_q == S6) ? S1 : s_state_e'(s_q + 3'd1);
        if ((s_q == S6) && (rem_q != '0)) rem_nxt = rem_q - 1'b1;
      end
    end
    // MOVX flags only mean something once the count says a data cycle exists
    if (end_instr) begin
      mv_rd_nxt   = 1'b0;
      mv_wr_nxt   = 1'b0;
      need_ld_nxt = 1'b1;
    end
    if (do_load) begin
      rem_nxt     = cyc_load_val;
      mv_rd_nxt   = movx_rd && (cyc_load_val != '0);
      mv_wr_nxt   = movx_wr && !movx_rd && (cyc_load_val != '0);
      need_ld_nxt = 1'b0;
    end
    data_nxt  = (rem_nxt == '0) && (mv_rd_nxt || mv_wr_nxt);
    pre_nxt   = (rem_nxt == CYC_W'(1)) && (mv_rd_nxt || mv_wr_nxt);
    enter_win = adv && (phase_nxt == P2) && ((s_nxt == S3) || (s_nxt == S6));
    enter_rdy = enter_win && (s_nxt == S3) && data_nxt;
  end

  // Strobes are computed from the state being entered so they change on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= P1;
      s_q       <= S6;
      rem_q     <= '0;
      mv_rd_q   <= 1'b0;
      mv_wr_q   <= 1'b0;
      need_ld_q <= 1'b0;
      ale       <= 1'b0;
      psen_n    <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      ir_en     <= 1'b0;
      dec_ld    <= 1'b0;
    end else if (stall_req) begin
      ir_en  <= 1'b0;
      dec_ld <= 1'b0;
    end else begin
      phase_q   <= phase_nxt;
      s_q       <= s_nxt;
      rem_q     <= rem_nxt;
      mv_rd_q   <= mv_rd_nxt;
      mv_wr_q   <= mv_wr_nxt;
      need_ld_q <= need_ld_nxt;
      ale       <= ale_on(phase_nxt, s_nxt, data_nxt);
      psen_n    <= !psen_on(phase_nxt, s_nxt, data_nxt, pre_nxt);
      rd_n      <= !(xstrobe_on(phase_nxt, s_nxt, data_nxt) && mv_rd_nxt);
      wr_n      <= !(xstrobe_on(phase_nxt, s_nxt, data_nxt) && mv_wr_nxt);
      ir_en     <= end_instr;
      dec_ld    <= do_load;
    end
  end

  assign phase      = phase_q;
  assign s_state    = s_q;
  assign cycles_rem = rem_q;

endmodule

// File: tb/tb_mcycle_timing_gen.sv
// Directed bench for mcycle_timing_gen: clock-by-clock timeline with
// hand-computed strobe counts, edge positions and state values.
module tb_mcycle_timing_gen;

  logic       clk = 1'b0;
  logic       reset, stall_req, movx_rd, movx_wr, xmem_ready;
  logic [1:0] cyc_load_val, wait_cfg;
  logic       phase, ale, psen_n, rd_n, wr_n, ir_en, dec_ld, waiting, bus_err;
  logic [2:0] s_state;
  logic [1:0] cycles_rem;

  always #5 clk = ~clk;

  mcycle_timing_gen #(.CYC_W(2), .WAIT_W(2), .RDY_TO(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_req    (stall_req),
    .cyc_load_val (cyc_load_val),
    .movx_rd      (movx_rd),
    .movx_wr      (movx_wr),
    .wait_cfg     (wait_cfg),
    .xmem_ready   (xmem_ready),
    .phase        (phase),
    .s_state      (s_state),
    .cycles_rem   (cycles_rem),
    .ale          (ale),
    .psen_n       (psen_n),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .ir_en        (ir_en),
    .dec_ld       (dec_ld),
    .waiting      (waiting),
    .bus_err      (bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int t = 0;
  int ale_hi, ale_rise, psen_lo, psen_fall, rd_lo, rd_fall_t, wr_lo, wr_rise_t;
  int wait_hi, err_cnt, err_t, ir_cnt, last_ir;
  logic ale_p = 1'b0, psen_p = 1'b1, rd_p = 1'b1, wr_p = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, t);
    end
  endtask

  task automatic clr();
    ale_hi = 0; ale_rise = 0; psen_lo = 0; psen_fall = 0;
    rd_lo = 0; rd_fall_t = -1; wr_lo = 0; wr_rise_t = -1;
    wait_hi = 0; err_cnt = 0; err_t = -1; ir_cnt = 0; last_ir = -1;
  endtask

  // One clock: sample 1 time unit after the edge and accumulate activity.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
    if (ale) ale_hi++;
    if (ale && !ale_p) ale_rise++;
    if (!psen_n) psen_lo++;
    if (!psen_n && psen_p) psen_fall++;
    if (!rd_n) rd_lo++;
    if (!rd_n && rd_p) rd_fall_t = t;
    if (!wr_n) wr_lo++;
    if (wr_n && !wr_p) wr_rise_t = t;
    if (waiting) wait_hi++;
    if (bus_err) begin err_cnt++; err_t = t; end
    if (ir_en) begin ir_cnt++; last_ir = t; end
    ale_p = ale; psen_p = psen_n; rd_p = rd_n; wr_p = wr_n;
  endtask

  initial begin
    reset = 1'b1; stall_req = 1'b0; movx_rd = 1'b0; movx_wr = 1'b0;
    xmem_ready = 1'b1; cyc_load_val = 2'd0; wait_cfg = 2'd0;
    clr();
    step(); step();
    chk("rst_phase", phase, 0);
    chk("rst_s", s_state, 6);
    chk("rst_rem", cycles_rem, 0);
    chk("rst_ale", ale, 0);
    chk("rst_psen", psen_n, 1);
    chk("rst_rd", rd_n, 1);
    chk("rst_wr", wr_n, 1);
    chk("rst_ir", ir_en, 0);
    chk("rst_decld", dec_ld, 0);
    chk("rst_wait", waiting, 0);
    chk("rst_err", bus_err, 0);

    // Basic sequencing, single-cycle instructions
    reset = 1'b0; t = 0;
    step();
    chk("t1_s", s_state, 6);
    chk("t1_phase", phase, 1);
    step();
    chk("t1_ir_first", ir_en, 1);
    chk("t1_s_wrap", s_state, 1);
    clr();
    step(); step();
    chk("t1_decld", dec_ld, 1);
    cyc_load_val = 2'd3;
    repeat (10) step();
    chk("t1_ir_cnt", ir_cnt, 1);
    chk("t1_ir_at", last_ir, 14);
    chk("t1_ale_hi", ale_hi, 4);
    chk("t1_ale_rise", ale_rise, 2);
    chk("t1_psen_lo", psen_lo, 6);
    chk("t1_psen_fall", psen_fall, 2);

    // Four-cycle instruction
    step(); step();
    chk("t2_decld", dec_ld, 1);
    chk("t2_rem_ld", cycles_rem, 3);
    cyc_load_val = 2'd0;
    clr();
    repeat (9) step();
    chk("t2_rem3", cycles_rem, 3);
    step();
    chk("t2_rem2", cycles_rem, 2);
    repeat (12) step();
    chk("t2_rem1", cycles_rem, 1);
    repeat (12) step();
    chk("t2_rem0", cycles_rem, 0);
    repeat (12) step();
    chk("t2_ir_cnt", ir_cnt, 1);
    chk("t2_ir_at", last_ir, 62);

    // MOVX read, one extra cycle
    movx_rd = 1'b1; cyc_load_val = 2'd1;
    step(); step();
    chk("t3_decld", dec_ld, 1);
    movx_rd = 1'b0; cyc_load_val = 2'd0;
    clr();
    repeat (22) step();
    chk("t3_ale_hi", ale_hi, 4);
    chk("t3_psen_lo", psen_lo, 6);
    chk("t3_rd_lo", rd_lo, 5);
    chk("t3_rd_fall", rd_fall_t, 75);
    chk("t3_wr_lo", wr_lo, 0);
    chk("t3_wait", wait_hi, 0);
    chk("t3_ir_at", last_ir, 86);

    // Two wait states per window
    wait_cfg = 2'd2;
    clr();
    repeat (16) step();
    chk("t4_ir_at_a", last_ir, 102);
    chk("t4_ir_cnt_a", ir_cnt, 1);
    chk("t4_wait_a", wait_hi, 4);
    clr();
    repeat (16) step();
    chk("t4_ir_at_b", last_ir, 118);
    chk("t4_wait_b", wait_hi, 4);
    wait_cfg = 2'd0;

    // MOVX write with memory never ready
    movx_wr = 1'b1; cyc_load_val = 2'd1; xmem_ready = 1'b0;
    step(); step();
    chk("t5_decld", dec_ld, 1);
    movx_wr = 1'b0; cyc_load_val = 2'd0;
    clr();
    repeat (37) step();
    chk("t5_wait", wait_hi, 15);
    chk("t5_err_cnt", err_cnt, 1);
    chk("t5_err_at", err_t, 150);
    chk("t5_wr_rise", wr_rise_t, 151);
    chk("t5_wr_lo", wr_lo, 20);
    chk("t5_rd_lo", rd_lo, 0);
    chk("t5_ir_at", last_ir, 157);
    xmem_ready = 1'b1;

    // Stall mid-S4, then reset while a MOVX strobe is low
    movx_rd = 1'b1; movx_wr = 1'b1; cyc_load_val = 2'd1;
    step(); step();
    chk("t6_decld", dec_ld, 1);
    movx_rd = 1'b0; movx_wr = 1'b0; cyc_load_val = 2'd0;
    repeat (5) step();
    chk("t6_pre_s", s_state, 4);
    chk("t6_pre_ale", ale, 1);
    stall_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_stall_s", s_state, 4);
      chk("t6_stall_ph", phase, 1);
      chk("t6_stall_ale", ale, 1);
      chk("t6_stall_psen", psen_n, 1);
      chk("t6_stall_rem", cycles_rem, 1);
    end
    stall_req = 1'b0;
    step();
    chk("t6_resume_s", s_state, 5);
    chk("t6_resume_ph", phase, 0);
    repeat (7) step();
    chk("t6_rd_low", rd_n, 0);
    chk("t6_wr_conf", wr_n, 1);
    chk("t6_s_s2", s_state, 2);
    reset = 1'b1;
    step();
    chk("t6_rst_rd", rd_n, 1);
    chk("t6_rst_s", s_state, 6);
    chk("t6_rst_ph", phase, 0);
    chk("t6_rst_rem", cycles_rem, 0);
    chk("t6_rst_ale", ale, 0);
    chk("t6_rst_psen", psen_n, 1);
    reset = 1'b0;
    step();
    chk("t6_re_ir0", ir_en, 0);
    step();
    chk("t6_re_ir1", ir_en, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mcycle_timing_gen.md
Name: mcycle_timing_gen

Overview:
- Parametrised successor to the MCU51 control-unit timing core.
- Generates phase and S1..S6 state sequencing, and counts multi-cycle instructions.
- Produces the external-bus strobes ALE, PSEN_n, RD_n and WR_n, and the opcode-latch pulses.
- Adds what the first generation lacks: programmable wait states, an external-memory ready handshake with timeout, a global stall/freeze, and wider cycle counts for long instructions.

Parameters:
- CYC_W, 2: width of the extra-machine-cycle count (instruction length = 1 + count).
- WAIT_W, 2: width of the programmable wait-state count.
- RDY_TO, 15: maximum clocks spent waiting on xmem_ready before the bus is forced on.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  reset, synchronous, active-high.
- stall_req  in  1  freeze the entire generator while high.
- cyc_load_val  in  CYC_W  extra machine cycles of the instruction now being decoded.
- movx_rd  in  1  instruction is a MOVX read; sampled with cyc_load_val.
- movx_wr  in  1  instruction is a MOVX write; sampled with cyc_load_val.
- wait_cfg  in  WAIT_W  extra clocks to insert per bus window.
- xmem_ready  in  1  external data memory ready.
- phase  out  1  0 = P1, 1 = P2.
- s_state  out  3  current state, S1..S6 encoded as 1..6.
- cycles_rem  out  CYC_W  machine cycles remaining after the current one.
- ale  out  1  address latch enable, active high.
- psen_n  out  1  program store enable, active low.
- rd_n  out  1  external read strobe, active low.
- wr_n  out  1  external write strobe, active low.
- ir_en  out  1  one-clock pulse: latch the opcode into IR.
- dec_ld  out  1  one-clock pulse: cyc_load_val, movx_rd and movx_wr sampled.
- waiting  out  1  a wait or ready hold is in progress.
- bus_err  out  1  one-clock pulse on ready timeout.

Behaviour:
- Reset:
  - phase = 0, s_state = 6, cycles_rem = 0.
  - ale = 0, psen_n = rd_n = wr_n = 1.
  - ir_en = dec_ld = waiting = bus_err = 0; internal MOVX flags and wait/timeout counters cleared.
  - Reset has priority over stall_req. Reset mid-instruction aborts it and deasserts all strobes on the next clock.
- Stall: while stall_req = 1, all state and outputs hold. Pulses are not re-issued or extended.
- Timing:
  - phase toggles every non-held clock; one S-state = 2 clocks.
  - s_state advances on each P2 -> P1 transition; S6 wraps to S1.
- Bus windows:
  - Windows are S3P2 and S6P2.
  - On entering a window, the wait counter loads wait_cfg and the block holds (phase and s_state frozen, waiting = 1) until the counter reaches 0.
  - wait_cfg = 0 gives no hold.
- Ready handshake:
  - Applies only at S3P2 of a MOVX data cycle, after the wait counter expires.
  - Hold additionally while xmem_ready = 0.
  - After RDY_TO held clocks, pulse bus_err and proceed.
  - If xmem_ready = 1 on the same clock the counter expires, proceed with no extra hold.
- Cycle counting:
  - At S6P2 with cycles_rem = 0 and not holding, the instruction ends: ir_en pulses.
  - At the next S1P2, dec_ld pulses and cycles_rem <= cyc_load_val; movx_rd and movx_wr are captured.
  - At S6P2 of any cycle with cycles_rem > 0, cycles_rem decrements.
  - Maximum instruction length is 2^CYC_W machine cycles.
- MOVX data cycle: the final cycle (cycles_rem = 0) of an instruction with a captured MOVX flag and captured count >= 1.
- ale:
  - High S1P2..S2P1 and S4P2..S5P1.
  - Suppressed during the S1P2..S2P1 window of a MOVX data cycle.
- psen_n:
  - Low S2P2..S3P2 and S5P2..S6P2, including waits.
  - Held high S2P2..S3P2 of a MOVX data cycle, and S5P2..S6P2 of the cycle preceding a MOVX data cycle.
- rd_n / wr_n: low S1P2..S3P2 of a MOVX data cycle, per captured flag, held through waits and ready holds.
- Flag conflict: movx_rd and movx_wr both 1 are treated as read; wr_n stays high.
- Registering: all outputs are registered, so strobe edges align to clock edges.

Decomposition:
- Shared package mcu51_timing_pkg holds:
  - S1..S6 encodings (1..6), P1/P2 constants;
  - a function that returns the extra-cycle count from an opcode; the decoder upstream uses it to drive cyc_load_val.
- One natural sub-module: bus_wait_ctrl. It owns the wait counter, the ready/timeout counter, waiting and bus_err, and returns a single hold signal to the sequencer.

Test Plan:
- Reset released, wait_cfg = 0, cyc_load_val = 0 -> ir_en at clock 2, then every 12 clocks; ale pulses twice and psen_n goes low twice per 12 clocks.
- cyc_load_val = 3 loaded at dec_ld -> cycles_rem reads 3, 2, 1, 0 across successive S6P2 edges; ir_en 48 clocks after the previous one.
- MOVX read, cyc_load_val = 1, xmem_ready = 1 -> second cycle shows no S1 ale and no S2/S3 psen_n; rd_n low for 5 clocks; wr_n stays 1.
- wait_cfg = 2 -> each bus window stretched by 2 clocks with waiting = 1; machine cycle = 16 clocks.
- MOVX write, xmem_ready held 0 -> 15 hold clocks, bus_err pulses once, wr_n rises at the following S3 -> S4 transition.
- stall_req high for 5 clocks mid-S4, then reset asserted during MOVX rd_n low -> outputs frozen during the stall; after reset, rd_n = 1 and s_state = 6 on the next clock.
